// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the detector benches.
package seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_e;

   localparam int                   SEQ_WIDTH   = 18;
   localparam logic [SEQ_WIDTH-1:0] SEQ_DEFAULT = 18'h0B269;

endpackage

// File: rtl/seq_generator_bit_counter.sv
// Mod-WIDTH bit index counter with synchronous clear and a terminal-count flag.
module bit_counter #(
   parameter int WIDTH = 18,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc  = (cnt_q == CNT_W'(WIDTH - 1));
   assign cnt = cnt_q;

   // Clear wins over enable; enable at terminal count wraps to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tc ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seq_generator.sv
// Programmable serial pattern source: shifts a WIDTH-bit pattern out LSB-first under start/done.
module seq_generator
   import seq_pkg::*;
#(
   parameter int               WIDTH           = SEQ_WIDTH,
   parameter int               CNT_W           = 5,
   parameter logic [WIDTH-1:0] DEFAULT_PATTERN = SEQ_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] pattern_in,
   input  logic             start,
   input  logic             loop,
   input  logic             halt,
   input  logic             bit_en,
   output logic             seq,
   output logic             seq_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_idx
);

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] pattern_q, pattern_d;
   logic             seq_q, seq_d;
   logic             done_q, done_d;

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;
   logic [CNT_W-1:0] nxt_idx;
   logic [WIDTH-1:0] nxt_bits;

   bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (bit_idx),
      .tc  (cnt_tc)
   );

   assign nxt_idx  = bit_idx + 1'b1;
   assign nxt_bits = pattern_q >> nxt_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pattern_q <= DEFAULT_PATTERN;
         seq_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         seq_q     <= seq_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      seq_d     = seq_q;
      done_d    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load)
               pattern_d = pattern_in;
            // A simultaneous load feeds bit 0 straight from pattern_in.
            if (start) begin
               state_d = RUN;
               cnt_clr = 1'b1;
               seq_d   = load ? pattern_in[0] : pattern_q[0];
            end
         end
         RUN: begin
            if (halt) begin
               state_d = IDLE;
               seq_d   = 1'b0;
               cnt_clr = 1'b1;
            end else if (bit_en) begin
               cnt_en = 1'b1;
               if (cnt_tc) begin
                  done_d = 1'b1;
                  if (loop) begin
                     seq_d = pattern_q[0];
                  end else begin
                     state_d = IDLE;
                     seq_d   = 1'b0;
                  end
               end else begin
                  seq_d = nxt_bits[0];
               end
            end
         end
         default: begin
            state_d = IDLE;
            seq_d   = 1'b0;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q == RUN);
      seq_valid = (state_q == RUN);
      seq       = seq_q;
      done      = done_q;
   end

endmodule

// File: tb/tb_seq_generator.sv
// Directed and randomized checks of seq_generator against a pattern-level expectation model.
module tb_seq_generator;

   localparam int          W   = 18;
   localparam logic [17:0] DEF = 18'h0B269;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] pattern_in;
   logic         start;
   logic         loop;
   logic         halt;
   logic         bit_en;
   logic         seq;
   logic         seq_valid;
   logic         busy;
   logic         done;
   logic [4:0]   bit_idx;

   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;
   int           cyc0   = 0;
   int           dc     = 0;
   logic [W-1:0] model_pat;
   logic [31:0]  rnd;

   seq_generator dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .pattern_in (pattern_in),
      .start      (start),
      .loop       (loop),
      .halt       (halt),
      .bit_en     (bit_en),
      .seq        (seq),
      .seq_valid  (seq_valid),
      .busy       (busy),
      .done       (done),
      .bit_idx    (bit_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic s, input logic v, input logic d, input int idx);
      chk({tag, ".seq"}, 32'(seq), 32'(s));
      chk({tag, ".valid"}, 32'(seq_valid), 32'(v));
      chk({tag, ".busy"}, 32'(busy), 32'(v));
      chk({tag, ".done"}, 32'(done), 32'(d));
      chk({tag, ".idx"}, 32'(bit_idx), 32'(idx));
   endtask

   // Move from bit i to the next edge that advances; idle strobes must hold bit i.
   task automatic adv(input int mode, input logic [W-1:0] pat, input int i);
      logic en;
      int   holds;
      holds = 0;
      case (mode)
         0: begin
            bit_en = 1'b1;
            tick();
         end
         1: begin
            do begin
               en = (holds >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
               bit_en = en;
               tick();
               if (!en) chk_out("hold", pat[i], 1'b1, 1'b0, i);
               holds++;
            end while (!en);
         end
         default: begin
            bit_en = 1'b0;
            tick();
            chk_out("toggle_hold", pat[i], 1'b1, 1'b0, i);
            bit_en = 1'b1;
            tick();
         end
      endcase
   endtask

   // Expect bits lo..hi-1 of pat; bit lo is already on the output.
   task automatic expect_pass(input logic [W-1:0] pat, input int mode, input logic d0, input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         if (i > lo) adv(mode, pat, i - 1);
         chk_out("bit", pat[i], 1'b1, (i == lo) && d0, i);
      end
   endtask

   task automatic end_pass(input int mode, input logic [W-1:0] pat, input logic lp, output int dcyc);
      loop = lp;
      adv(mode, pat, W - 1);
      dcyc = cyc;
      if (!lp) begin
         chk_out("stop", 1'b0, 1'b0, 1'b1, 0);
         tick();
         chk_out("idle", 1'b0, 1'b0, 1'b0, 0);
      end
   endtask

   task automatic do_start(input logic ld, input logic [W-1:0] pin);
      load       = ld;
      pattern_in = pin;
      start      = 1'b1;
      if (ld) model_pat = pin;
      tick();
      load  = 1'b0;
      start = 1'b0;
      cyc0  = cyc;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; pattern_in = '0; start = 1'b0;
      loop = 1'b0; halt = 1'b0; bit_en = 1'b1;
      model_pat = DEF;
      tick();
      tick();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 0);
      rst = 1'b0;
      tick();
      chk_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 0);

      // Default pattern, single pass
      do_start(1'b0, '0);
      expect_pass(model_pat, 0, 1'b0, 0, W);
      end_pass(0, model_pat, 1'b0, dc);
      chk("default_done_cycle", 32'(dc - cyc0 + 1), 32'd19);

      // Load with start; later load/start during RUN must be ignored
      do_start(1'b1, 18'h3FFFE);
      load = 1'b1; pattern_in = '0; start = 1'b1;
      expect_pass(model_pat, 0, 1'b0, 0, W);
      loop = 1'b0;
      bit_en = 1'b1;
      tick();
      chk_out("ld_stop", 1'b0, 1'b0, 1'b1, 0);
      load = 1'b0; start = 1'b0;
      tick();
      chk_out("ld_idle", 1'b0, 1'b0, 1'b0, 0);
      do_start(1'b0, '0);
      expect_pass(model_pat, 1, 1'b0, 0, W);
      end_pass(1, model_pat, 1'b0, dc);

      // Three looped passes, loop cleared mid third pass
      do_start(1'b1, DEF);
      expect_pass(model_pat, 0, 1'b0, 0, W);
      end_pass(0, model_pat, 1'b1, dc);
      chk("loop_done1", 32'(dc - cyc0 + 1), 32'd19);
      expect_pass(model_pat, 0, 1'b1, 0, W);
      end_pass(0, model_pat, 1'b1, dc);
      chk("loop_done2", 32'(dc - cyc0 + 1), 32'd37);
      expect_pass(model_pat, 0, 1'b1, 0, 9);
      loop = 1'b0;
      adv(0, model_pat, 8);
      expect_pass(model_pat, 0, 1'b0, 9, W);
      end_pass(0, model_pat, 1'b0, dc);
      chk("loop_done3", 32'(dc - cyc0 + 1), 32'd55);

      // bit_en toggling: each bit held two cycles
      do_start(1'b0, '0);
      expect_pass(model_pat, 2, 1'b0, 0, W);
      end_pass(2, model_pat, 1'b0, dc);
      chk("toggle_len", 32'(dc - cyc0 + 1), 32'd37);

      // Halt at bit 7, then restart from bit 0
      do_start(1'b0, '0);
      expect_pass(model_pat, 0, 1'b0, 0, 8);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk_out("halt", 1'b0, 1'b0, 1'b0, 0);
      tick();
      chk_out("halt_idle", 1'b0, 1'b0, 1'b0, 0);
      do_start(1'b0, '0);
      expect_pass(model_pat, 0, 1'b0, 0, W);
      end_pass(0, model_pat, 1'b0, dc);

      // Reset mid-pass restores the default pattern
      load = 1'b1; pattern_in = 18'h15555;
      tick();
      load = 1'b0;
      model_pat = 18'h15555;
      chk_out("load_idle", 1'b0, 1'b0, 1'b0, 0);
      do_start(1'b0, '0);
      expect_pass(model_pat, 0, 1'b0, 0, 11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_pat = DEF;
      chk_out("mid_reset", 1'b0, 1'b0, 1'b0, 0);
      do_start(1'b0, '0);
      expect_pass(model_pat, 0, 1'b0, 0, W);
      end_pass(0, model_pat, 1'b0, dc);

      // Random patterns with random advance strobes and occasional looping
      for (int k = 0; k < 6; k++) begin
         rnd = $urandom;
         do_start(1'b1, rnd[W-1:0]);
         expect_pass(model_pat, 1, 1'b0, 0, W);
         if (rnd[31]) begin
            end_pass(1, model_pat, 1'b1, dc);
            expect_pass(model_pat, 1, 1'b1, 0, W);
         end
         end_pass(1, model_pat, 1'b0, dc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_generator.md
# seq_generator

Programmable serial pattern source that drives the `seq` input of `seq_detector`. It holds a WIDTH-bit pattern register and shifts the pattern out LSB-first, one bit per enabled clock, under a start/done handshake. It supports single-pass and continuous (loop) operation, so the detector can be exercised on hardware without a testbench stimulus process.

## Interface
Parameters:
- `WIDTH`, 18: pattern length in bits (2..32).
- `CNT_W`, 5: width of `bit_idx`; must satisfy 2^CNT_W ≥ WIDTH.
- `DEFAULT_PATTERN`, 18'h0B269 (18'b001_01100100_1101001): pattern register value after reset.

Ports. Single clock `clk`. `rst` is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `load`  in  1  capture `pattern_in` into the pattern register (IDLE only).
- `pattern_in`  in  WIDTH  new pattern.
- `start`  in  1  begin emission (IDLE only).
- `loop`  in  1  1 = wrap to bit 0 after the last bit; 0 = stop.
- `halt`  in  1  abort emission and return to IDLE.
- `bit_en`  in  1  advance strobe; tie to 1 for one bit per clock.
- `seq`  out  1  serial bit to the detector (registered).
- `seq_valid`  out  1  `seq` carries a pattern bit.
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse at the end of each full pass.
- `bit_idx`  out  CNT_W  index of the bit currently on `seq`.

## Operation
- States: IDLE, RUN.
- Reset sets all outputs to 0, state to IDLE, and the pattern register to DEFAULT_PATTERN.
- IDLE:
  - `load`=1 → pattern ← `pattern_in`.
  - `start`=1 → RUN, `bit_idx`←0, `seq`←pattern[0], `seq_valid`←1.
  - If `load` and `start` are both high, the new `pattern_in` is used for the pass, and bit 0 is taken from `pattern_in` directly.
- RUN, edge with `bit_en`=1:
  - `bit_idx` < WIDTH-1 → increment; `seq`←pattern[bit_idx+1].
  - `bit_idx` = WIDTH-1, `loop`=1 → `bit_idx`←0, `seq`←pattern[0], `done`←1, remain in RUN with no gap.
  - `bit_idx` = WIDTH-1, `loop`=0 → IDLE, `seq`←0, `seq_valid`←0, `bit_idx`←0, `done`←1.
- RUN, `bit_en`=0: all outputs hold, `done`=0.
- `loop` is sampled only at the wrap point, so clearing it mid-pass finishes the current pass.
- `halt`=1 in RUN → IDLE next edge. `seq`, `seq_valid`, `bit_idx` clear; no `done` pulse.
- Ignored inputs: `load` and `start` in RUN; `halt` and `bit_en` in IDLE.
- Priority: `rst` > `halt` > advance/wrap > `load`/`start`.

## Timing
- All outputs are registered. Start latency is 1 cycle: with `start` sampled at edge N, `seq`=pattern[0] is valid after edge N.
- `bit_en` is not required on the start edge.
- A pass with `bit_en` held high lasts exactly WIDTH cycles. `done` asserts in the cycle after the last bit, concurrent with `seq_valid`=0 (stop) or with `seq`=pattern[0] (loop).
- `busy` equals (state == RUN) and `seq_valid` equals `busy`.
- Reset in mid-pass takes effect at the next edge: outputs 0, pattern returns to default, and no `done`.
- `done` is never high for two consecutive cycles unless WIDTH passes complete back-to-back, which is not possible for WIDTH ≥ 2.

## Structure
- Shared package `seq_pkg`:
  - state enum {IDLE, RUN};
  - `SEQ_WIDTH`=18;
  - `SEQ_DEFAULT`=18'h0B269 (also used by `seq_detector` benches).
- Sub-module `bit_counter`: mod-WIDTH counter with clear, enable, and a terminal-count flag (`bit_idx`==WIDTH-1). Everything else is the top-level FSM and the pattern register.

## Test plan
- Reset, then `start` with `bit_en`=1, `loop`=0 → `seq` over 18 cycles = 1,0,0,1,0,1,1,0,0,1,0,0,1,1,0,1,0,0. `done` pulses in cycle 19 with `seq_valid`=0; `busy` is 0 afterwards.
- `load` `pattern_in`=18'h3FFFE with `start` on the same cycle → first `seq`=0, then seventeen 1s. A `load` of 18'h00000 during RUN has no effect on the pass.
- `loop`=1 for 3 passes → 54 contiguous valid bits, `done` pulses at cycles 19, 37, 55. Clear `loop` during pass 3 → IDLE after bit 17 of pass 3.
- `bit_en` toggling 1,0,1,0 → each bit held 2 cycles, the pass lasts 36 cycles, and `bit_idx` sequence is 0,0,1,1,2,2…
- `halt` at `bit_idx`=7 → next cycle `busy`=0, `seq_valid`=0, `bit_idx`=0, no `done`. `start` then restarts from bit 0.
- `rst` at `bit_idx`=10 after loading 18'h15555 → all outputs 0, and the next pass emits the default pattern.
